// File: rtl/nbody_force_row.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : nbody_force_row                                               |
// | Purpose  : Linear systolic row of P processing elements. Each PE holds   |
// |            one resident i-body; j-bodies stream through a P-stage shift  |
// |            pipeline and every PE accumulates the 1-D gravitational term  |
// |            m_i*m_j*(q_j-q_i)/|q_j-q_i|^3 in signed Q.FRAC fixed point.   |
// | Ports    : clk, rst_n          clock, async active-low reset             |
// |            start               IDLE->LOAD, clears accumulators/slots     |
// |            ld_*                i-body load channel (LOAD state)          |
// |            s_*                 j-body stream channel (STREAM state)      |
// |            m_*                 per-slot result channel (UNLOAD state)    |
// |            busy                high whenever the row is not IDLE         |
// |            sat_flag            sticky accumulator saturation (optional)  |
// | Options  : NBODY_SAT_ACC_EN    defined: saturating accumulation plus     |
// |                                sat_flag port; undefined: wrapping adds   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module nbody_force_row #(
  parameter int P        = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int ACC_W    = 24,
  parameter int IDXW     = 8,
  parameter int MIN_DIST = 1,
  localparam int SLOT_W  = (P > 1) ? $clog2(P) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [SLOT_W-1:0]       ld_slot,
  input  logic signed [W-1:0]     ld_q,
  input  logic [W-1:0]            ld_m,
  input  logic [IDXW-1:0]         ld_idx,
  input  logic                    ld_last,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [W-1:0]     s_q,
  input  logic [W-1:0]            s_m,
  input  logic [IDXW-1:0]         s_idx,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [IDXW-1:0]         m_idx,
  output logic signed [ACC_W-1:0] m_force,
  output logic                    m_last,
`ifdef NBODY_SAT_ACC_EN
  output logic                    sat_flag,
`endif
  output logic                    busy
);

  // Full-precision datapath widths: (m_i*m_j) is 2W unsigned, times r (W+1
  // signed) gives 3W+2 signed, then FRAC more bits for the fixed-point shift.
  localparam int PROD_W = 3*W + 2;
  localparam int NUM_W  = PROD_W + FRAC;
  localparam int CUBE_W = 3*(W + 1);
  localparam int DIV_W  = (NUM_W > CUBE_W + 1) ? NUM_W : CUBE_W + 1;

  localparam logic signed [DIV_W-1:0] c_acc_max =
    {{(DIV_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [DIV_W-1:0] c_acc_min =
    {{(DIV_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  // Resident i-body slots
  logic signed [W-1:0]   r_iq   [P];
  logic [W-1:0]          r_im   [P];
  logic [IDXW-1:0]       r_iidx [P];
  logic [P-1:0]          r_ivld;

  // j-body shift pipeline
  logic signed [W-1:0]   r_pq   [P];
  logic [W-1:0]          r_pm   [P];
  logic [IDXW-1:0]       r_pidx [P];
  logic [P-1:0]          r_pv;

  logic [SLOT_W-1:0]            r_out_slot;
  logic [P-1:0][ACC_W-1:0]      w_acc_all;

  logic w_start, w_ld_fire, w_s_fire, w_m_fire, w_out_vld;

  assign w_start   = start && (r_state == S_IDLE);
  assign w_ld_fire = ld_valid && (r_state == S_LOAD);
  assign w_s_fire  = s_valid && (r_state == S_STREAM);
  assign w_m_fire  = m_ready && (r_state == S_UNLOAD);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start)                w_state_nxt = S_LOAD;
      S_LOAD:   if (ld_valid && ld_last)  w_state_nxt = S_STREAM;
      S_STREAM: if (s_valid && s_last)    w_state_nxt = S_DRAIN;
      // Leave only once the last token has left stage P-1 and been summed.
      S_DRAIN:  if (r_pv == '0)           w_state_nxt = S_UNLOAD;
      S_UNLOAD: if (m_ready && (r_out_slot == SLOT_W'(P-1)))
                                          w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- slot load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ivld <= '0;
      for (int k = 0; k < P; k++) begin
        r_iq[k]   <= '0;
        r_im[k]   <= '0;
        r_iidx[k] <= '0;
      end
    end else if (w_start) begin
      r_ivld <= '0;
    end else if (w_ld_fire && (int'(ld_slot) < P)) begin
      r_ivld[ld_slot] <= 1'b1;
      r_iq[ld_slot]   <= ld_q;
      r_im[ld_slot]   <= ld_m;
      r_iidx[ld_slot] <= ld_idx;
    end
  end

  // ------------------------------------------------------ j pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      for (int k = 0; k < P; k++) begin
        r_pq[k]   <= '0;
        r_pm[k]   <= '0;
        r_pidx[k] <= '0;
      end
    end else begin
      r_pv[0]   <= w_s_fire;
      r_pq[0]   <= s_q;
      r_pm[0]   <= s_m;
      r_pidx[0] <= s_idx;
      for (int k = 1; k < P; k++) begin
        r_pv[k]   <= r_pv[k-1];
        r_pq[k]   <= r_pq[k-1];
        r_pm[k]   <= r_pm[k-1];
        r_pidx[k] <= r_pidx[k-1];
      end
    end
  end

`ifdef NBODY_SAT_ACC_EN
  logic [P-1:0] w_sat_hit;
  logic         r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_sat <= 1'b0;
    else if (w_start)   r_sat <= 1'b0;
    else if (|w_sat_hit) r_sat <= 1'b1;
  end

  assign sat_flag = r_sat;
`endif

  // ------------------------------------------------------ PEs
  for (genvar k = 0; k < P; k++) begin : g_pe
    logic signed [W:0]        w_r;
    logic [W:0]               w_abs;
    logic [2*W-1:0]           w_mm;
    logic signed [PROD_W-1:0] w_prod;
    logic [CUBE_W-1:0]        w_absx;
    logic [CUBE_W-1:0]        w_abs3;
    logic signed [DIV_W-1:0]  w_num;
    logic signed [DIV_W-1:0]  w_den;
    logic signed [DIV_W-1:0]  w_quo;
    logic                     w_skip;
    logic signed [ACC_W-1:0]  w_f;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic signed [ACC_W-1:0]  r_acc;

    always_comb begin
      w_r    = {r_pq[k][W-1], r_pq[k]} - {r_iq[k][W-1], r_iq[k]};
      w_abs  = w_r[W] ? $unsigned(-w_r) : $unsigned(w_r);
      w_mm   = {{W{1'b0}}, r_im[k]} * {{W{1'b0}}, r_pm[k]};
      w_prod = PROD_W'($signed({1'b0, w_mm})) * PROD_W'(w_r);
      w_absx = CUBE_W'(w_abs);
      w_abs3 = w_absx * w_absx * w_absx;
      // Zero |r| is always excluded so the divider never sees 0.
      w_skip = !r_ivld[k] || (r_pidx[k] == r_iidx[k]) ||
               (w_abs < (W+1)'(MIN_DIST)) || (w_abs == '0);
      w_num  = DIV_W'(w_prod) <<< FRAC;
      w_den  = w_skip ? DIV_W'(1) : DIV_W'($signed({1'b0, w_abs3}));
      // Signed division truncates toward zero.
      w_quo  = w_num / w_den;
      if (w_skip)                 w_f = '0;
      else if (w_quo > c_acc_max) w_f = c_acc_max[ACC_W-1:0];
      else if (w_quo < c_acc_min) w_f = c_acc_min[ACC_W-1:0];
      else                        w_f = w_quo[ACC_W-1:0];
    end

`ifdef NBODY_SAT_ACC_EN
    logic signed [ACC_W:0] w_sum;
    logic                  w_sat;

    always_comb begin
      w_sum     = {r_acc[ACC_W-1], r_acc} + {w_f[ACC_W-1], w_f};
      w_sat     = 1'b0;
      w_acc_nxt = w_sum[ACC_W-1:0];
      // Overflow when the extra sign bit disagrees with the result sign.
      if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
        w_sat     = r_pv[k];
        w_acc_nxt = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end

    assign w_sat_hit[k] = w_sat;
`else
    assign w_acc_nxt = r_acc + w_f;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_acc <= '0;
      else if (w_start) r_acc <= '0;
      else if (r_pv[k]) r_acc <= w_acc_nxt;
    end

    assign w_acc_all[k] = r_acc;
  end

  // ------------------------------------------------------ unload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_out_slot <= '0;
    else if (w_start)  r_out_slot <= '0;
    else if (w_m_fire) r_out_slot <= r_out_slot + 1'b1;
  end

  assign w_out_vld = m_valid && r_ivld[r_out_slot];

  assign ld_ready = (r_state == S_LOAD);
  assign s_ready  = (r_state == S_STREAM);
  assign m_valid  = (r_state == S_UNLOAD);
  assign m_last   = m_valid && (r_out_slot == SLOT_W'(P-1));
  assign busy     = (r_state != S_IDLE);
  // Unloaded slots report idx 0 and force 0.
  assign m_idx    = w_out_vld ? r_iidx[r_out_slot] : '0;
  assign m_force  = w_out_vld ? $signed(w_acc_all[r_out_slot]) : '0;

endmodule
`default_nettype wire
